// File: rtl/video_capture.sv
// rtl/video_capture.sv - VGA frame grabber: thresholds pixels to 1bpp, packs bytes, measures sync timing
module video_capture #(
  parameter int X0     = 32,
  parameter int Y0     = 28,
  parameter int W      = 256,
  parameter int H      = 184,
  parameter int THRESH = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_de,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        locked,
  output logic [9:0]  htotal,
  output logic [9:0]  vtotal,
  output logic        frame_done
);

  localparam logic [12:0] X_LO = 13'(X0);
  localparam logic [12:0] X_HI = 13'(X0 + W);
  localparam logic [12:0] Y_LO = 13'(Y0);
  localparam logic [12:0] Y_HI = 13'(Y0 + H);
  localparam logic [12:0] BPL  = 13'(W / 8);
  localparam logic [5:0]  THR  = 6'(THRESH);
  localparam logic [9:0]  SAT  = 10'h3FF;

  typedef enum logic {WAIT_VS, CAPTURE} state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_p_q, vs_q, vs_p_q, de_q, de_p_q;
  logic [3:0]  r_q, g_q, b_q;
  logic [9:0]  px_q, px_d;
  logic [9:0]  ln_q, ln_d;
  logic [7:0]  sh_q, sh_d;
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [9:0]  htotal_q, htotal_d;
  logic [9:0]  vtotal_q, vtotal_d;
  logic [9:0]  htot_frame_q, htot_frame_d;
  logic        hbad_q, hbad_d;
  logic        locked_q, locked_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic        frame_done_q, frame_done_d;

  logic        hs_fall, vs_fall, de_rise, de_fall;
  logic [9:0]  px_cur;
  logic [12:0] x_ext, y_ext, x_off, y_off, lin_addr;
  logic        in_win, sample, pix_bit, byte_done;
  logic [5:0]  pix_sum;
  logic [7:0]  sh_base;
  logic [10:0] hmeas11;
  logic [9:0]  hmeas, htot_new;
  logic        hmis;

  // Next-state logic: edge detection, pixel packing, timing measurement and lock tracking
  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    ln_d         = ln_q;
    sh_d         = sh_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    htotal_d     = htotal_q;
    vtotal_d     = vtotal_q;
    htot_frame_d = htot_frame_q;
    hbad_d       = hbad_q;
    locked_d     = locked_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    frame_done_d = 1'b0;

    hs_fall = hs_p_q & ~hs_q;
    vs_fall = vs_p_q & ~vs_q;
    de_rise = de_q & ~de_p_q;
    de_fall = ~de_q & de_p_q;

    // The first active pixel of a line sees px=0 even though px_q still holds the old line's count
    px_cur  = de_rise ? 10'd0 : px_q;
    x_ext   = {4'b0, px_cur[9:1]};
    y_ext   = {4'b0, ln_q[9:1]};
    x_off   = x_ext - X_LO;
    y_off   = y_ext - Y_LO;
    in_win  = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
    sample  = de_q && !px_cur[0] && !ln_q[0] && in_win;
    pix_sum = {2'b0, r_q} + {2'b0, g_q} + {2'b0, b_q};
    pix_bit = (pix_sum >= THR);
    sh_base = de_rise ? 8'd0 : sh_q;
    byte_done = sample && (x_off[2:0] == 3'd7);
    lin_addr  = y_off * BPL + (x_off >> 3);

    if (de_q) px_d = px_cur + 10'd1;
    if (sample) sh_d = {sh_base[6:0], pix_bit};
    else        sh_d = sh_base;

    if (vs_fall)                      ln_d = 10'd0;
    else if (de_fall && ln_q != SAT)  ln_d = ln_q + 10'd1;

    if (byte_done && state_q == CAPTURE) begin
      wr_en_d   = 1'b1;
      wr_data_d = sh_d;
      wr_addr_d = lin_addr;
    end

    hmeas11  = {1'b0, hcnt_q} + 11'd1;
    hmeas    = hmeas11[10] ? SAT : hmeas11[9:0];
    hmis     = hs_fall && (htotal_q != 10'd0) && (hmeas != htotal_q);
    htot_new = hs_fall ? hmeas : htotal_q;

    if (hs_fall) begin
      hcnt_d   = 10'd0;
      htotal_d = hmeas;
      if (hmeas != htotal_q) locked_d = 1'b0;
      if (hmis) hbad_d = 1'b1;
    end else if (hcnt_q != SAT) begin
      hcnt_d = hcnt_q + 10'd1;
    end

    if (hs_fall && vcnt_q != SAT) vcnt_d = vcnt_q + 10'd1;

    // A coincident hs edge belongs to the frame that the vs edge opens
    if (vs_fall) begin
      vtotal_d     = vcnt_q;
      vcnt_d       = hs_fall ? 10'd1 : 10'd0;
      htot_frame_d = htot_new;
      hbad_d       = 1'b0;
      if (vcnt_q != vtotal_q)
        locked_d = 1'b0;
      else if (!hbad_q && !hmis && htot_new == htot_frame_q)
        locked_d = 1'b1;
      if (state_q == CAPTURE) frame_done_d = 1'b1;
      else                    state_d = CAPTURE;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= WAIT_VS;
      hs_q         <= 1'b1;
      hs_p_q       <= 1'b1;
      vs_q         <= 1'b1;
      vs_p_q       <= 1'b1;
      de_q         <= 1'b0;
      de_p_q       <= 1'b0;
      r_q          <= 4'd0;
      g_q          <= 4'd0;
      b_q          <= 4'd0;
      px_q         <= 10'd0;
      ln_q         <= 10'd0;
      sh_q         <= 8'd0;
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      htotal_q     <= 10'd0;
      vtotal_q     <= 10'd0;
      htot_frame_q <= 10'd0;
      hbad_q       <= 1'b0;
      locked_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 8'd0;
      wr_addr_q    <= 13'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_q         <= vga_hs;
      hs_p_q       <= hs_q;
      vs_q         <= vga_vs;
      vs_p_q       <= vs_q;
      de_q         <= vga_de;
      de_p_q       <= de_q;
      r_q          <= vga_r;
      g_q          <= vga_g;
      b_q          <= vga_b;
      px_q         <= px_d;
      ln_q         <= ln_d;
      sh_q         <= sh_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      htotal_q     <= htotal_d;
      vtotal_q     <= vtotal_d;
      htot_frame_q <= htot_frame_d;
      hbad_q       <= hbad_d;
      locked_q     <= locked_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign locked     = locked_q;
  assign htotal     = htotal_q;
  assign vtotal     = vtotal_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_video_capture.sv
// tb/tb_video_capture.sv - scoreboard bench for video_capture on a scaled-down video timing
module tb_video_capture;

  localparam int X0 = 2, Y0 = 1, W = 16, H = 3, THRESH = 23;
  localparam int HT = 56, HS_W = 4, DE_S = 10, DE_N = 40;
  localparam int VT = 20, VS_W = 2, VA_S = 4, VA_N = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_hs, vga_vs, vga_de;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en, locked, frame_done;
  logic [9:0]  htotal, vtotal;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  fd_count = 0;

  video_capture #(.X0(X0), .Y0(Y0), .W(W), .H(H), .THRESH(THRESH)) dut (
    .clk(clk), .reset(reset),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .locked(locked), .htotal(htotal), .vtotal(vtotal), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed byte for each pixel pattern over the capture window
  function automatic logic [7:0] mode_byte(input int mode);
    case (mode)
      1:       return 8'hAA;
      2:       return 8'hCC;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic set_color(input int mode, input int px);
    int x;
    x = px / 2;
    case (mode)
      1: begin
        if ((px % 4) < 2) begin vga_r = 4'd15; vga_g = 4'd15; vga_b = 4'd15; end
        else              begin vga_r = 4'd0;  vga_g = 4'd0;  vga_b = 4'd0;  end
      end
      2: begin
        vga_r = 4'd15; vga_b = 4'd0;
        vga_g = ((x % 4) >= 2) ? 4'd8 : 4'd7;
      end
      default: begin vga_r = 4'd15; vga_g = 4'd15; vga_b = 4'd15; end
    endcase
  endtask

  // Scoreboard monitor: every write strobe pops one expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0d/%0h expected=none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic run_frame(input int mode, input bit expw, input int chg_line, input int chg_ht,
                           input int trunc_line, input int trunc_px, input int rst_line,
                           input int lck_line, input bit lck_val);
    bit aborted = 1'b0;
    int ht, npx, a, last_px;
    for (int ln = 0; ln < VT; ln++) begin
      ht  = (chg_line >= 0 && ln >= chg_line) ? chg_ht : HT;
      a   = ln - VA_S;
      npx = (ln == trunc_line) ? trunc_px : DE_N;
      for (int h = 0; h < ht; h++) begin
        vga_hs = (h >= HS_W);
        vga_vs = (ln >= VS_W);
        vga_de = (a >= 0 && a < VA_N && h >= DE_S && h < DE_S + npx);
        if (vga_de) set_color(mode, h - DE_S);
        else begin vga_r = 4'd0; vga_g = 4'd0; vga_b = 4'd0; end
        reset = !(ln == rst_line && h == 0);
        if (h == 1 && ln == lck_line) check("lock_loss_line", 32'(locked), 32'(lck_val));
        if (h == 1 && expw && !aborted && a >= 0 && a < VA_N && (a % 2) == 0 &&
            (a / 2) >= Y0 && (a / 2) < Y0 + H) begin
          for (int b = 0; b < W / 8; b++) begin
            last_px = 2 * (X0 + 8 * b + 7);
            if (last_px < npx) exp_q.push_back('{addr: 13'((a / 2 - Y0) * (W / 8) + b), data: mode_byte(mode)});
          end
        end
        tick();
        if (ln == rst_line && h == 0) begin
          check("midframe_reset_outputs",
                {wr_addr, wr_data, wr_en, locked, htotal, vtotal, frame_done}, 32'd0);
          aborted = 1'b1;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    vga_r = 4'd0; vga_g = 4'd0; vga_b = 4'd0;
    tick(); tick(); tick();
    check("reset_outputs", {wr_addr, wr_data, wr_en, locked, htotal, vtotal, frame_done}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    run_frame(0, 1, -1, 0, -1, 0, -1, -1, 1'b0);
    check("locked_frame1", 32'(locked), 32'd0);
    run_frame(0, 1, -1, 0, -1, 0, -1, -1, 1'b0);
    check("htotal_frame2", 32'(htotal), 32'd56);
    check("vtotal_frame2", 32'(vtotal), 32'd20);
    check("locked_frame2", 32'(locked), 32'd0);
    run_frame(0, 1, -1, 0, -1, 0, -1, -1, 1'b0);
    check("locked_frame3", 32'(locked), 32'd1);

    run_frame(1, 1, -1, 0, -1, 0, -1, -1, 1'b0);
    run_frame(2, 1, -1, 0, -1, 0, -1, -1, 1'b0);
    run_frame(0, 1, -1, 0, VA_S + 2, 30, -1, -1, 1'b0);
    check("locked_stable", 32'(locked), 32'd1);

    run_frame(0, 1, 10, HT + 1, -1, 0, -1, 12, 1'b0);
    check("locked_after_change", 32'(locked), 32'd0);
    check("htotal_changed", 32'(htotal), 32'd57);
    run_frame(0, 1, 0, HT + 1, -1, 0, -1, -1, 1'b0);
    check("locked_one_stable_frame", 32'(locked), 32'd0);
    run_frame(0, 1, 0, HT + 1, -1, 0, -1, -1, 1'b0);
    check("locked_recovered", 32'(locked), 32'd1);
    check("vtotal_recovered", 32'(vtotal), 32'd20);

    run_frame(0, 1, -1, 0, -1, 0, VA_S + 4, -1, 1'b0);
    check("sb_drained_before_post_reset", 32'(exp_q.size()), 32'd0);
    run_frame(0, 1, -1, 0, -1, 0, -1, -1, 1'b0);

    vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("frame_done_count", 32'(fd_count), 32'd9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 Parameter X0, default 32: first captured column, in half-resolution pixels.
REQ-002 Parameter Y0, default 28: first captured row, in half-resolution lines.
REQ-003 Parameter W, default 256: capture width in half-resolution pixels; always a multiple of 8.
REQ-004 Parameter H, default 184: capture height in half-resolution lines.
REQ-005 Parameter THRESH, default 23: luma threshold applied to r+g+b (6-bit sum).
REQ-006 clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 vga_hs  in  1  horizontal sync, active low.
REQ-009 vga_vs  in  1  vertical sync, active low.
REQ-010 vga_de  in  1  data enable, high during active pixels.
REQ-011 vga_r / vga_g / vga_b  in  4 each  pixel colour.
REQ-012 wr_addr  out  13  frame-buffer byte address.
REQ-013 wr_data  out  8  packed 1bpp pixels; MSB is the leftmost pixel.
REQ-014 wr_en  out  1  single-cycle write strobe.
REQ-015 locked  out  1  high while the measured timing is stable.
REQ-016 htotal  out  10  clocks between consecutive hs falling edges, saturating at 1023.
REQ-017 vtotal  out  10  hs falling edges between consecutive vs falling edges, saturating at 1023.
REQ-018 frame_done  out  1  one-cycle pulse on each vs falling edge while in CAPTURE.

Function
REQ-019 Sync edges: hs and vs are registered once; a falling edge is previous=1, current=0. All timing references these registered copies.
REQ-020 States:
- WAIT_VS: no writes; go to CAPTURE on vs falling edge.
- CAPTURE: capture active.
- On vs falling edge in CAPTURE: stay in CAPTURE, pulse frame_done.
REQ-021 Pixel counter px (10 bits): cleared on registered-de rising edge; increments each cycle registered-de is high.
REQ-022 Line counter ln (10 bits): cleared on vs falling edge; increments on each de falling edge; saturates at 1023.
REQ-023 Half-resolution coordinates: x = px>>1, y = ln>>1. Sample only when px[0]=0 and ln[0]=0.
REQ-024 Pixel bit = 1 when vga_r+vga_g+vga_b (6-bit, zero-extended) >= THRESH, else 0.
REQ-025 Sampling window: X0 <= x < X0+W and Y0 <= y < Y0+H. Sampled bits shift into an 8-bit register, MSB first.
REQ-026 Write: when the sample with (x-X0)[2:0]=7 is taken, then one cycle later:
- wr_en=1 for exactly one cycle;
- wr_data = completed byte;
- wr_addr = (y-Y0)*(W/8) + ((x-X0)>>3), truncated to 13 bits.
REQ-027 Writes occur only in CAPTURE. The shift register clears on every de rising edge, so a truncated line never emits a partial byte.
REQ-028 htotal measurement: a clock counter restarts at 0 on each hs falling edge. On that edge htotal is loaded with the previous count+1 (saturating at 1023).
REQ-029 vtotal measurement: an hs-edge counter restarts on each vs falling edge. On that edge vtotal is loaded with the count.
REQ-030 Lock acquisition: locked rises on a vs falling edge when the just-measured vtotal and htotal equal the values from the previous frame, and nonzero htotal mismatches were absent during the frame.
REQ-031 Lock loss: locked falls on any hs edge whose measured line length differs from htotal, or on any vs edge with a vtotal mismatch.
REQ-032 Capture is not gated by locked.
REQ-033 Simultaneous hs and vs falling edges: both are processed in the same cycle. The vs edge takes precedence for clearing ln.

Reset
REQ-034 While reset=0, all outputs go to 0 (wr_addr, wr_data, wr_en, locked, htotal, vtotal, frame_done); all counters and the shift register clear; state = WAIT_VS.
REQ-035 Reset asserted mid-frame aborts capture. No wr_en occurs until after the first vs falling edge following reset release.

Verification
REQ-036 640x480 stimulus (800x525 total, hs 96 clk, vs 2 lines), all pixels white -> htotal=800 and vtotal=525 after the second frame; locked=1 after the third vs falling edge; 5888 writes per frame, all wr_data=0xFF, wr_addr 0..5887 in order.
REQ-037 Alternating white/black every 2 clocks -> every wr_data=0xAA.
REQ-038 Line length changed to 801 mid-frame -> locked falls within 2 hs edges of the change and recovers two frames after stable timing resumes.
REQ-039 Reset pulse at line 200 -> outputs 0 in the next cycle; no wr_en before the next vs falling edge; the first post-reset write has wr_addr=0.
REQ-040 Pixel sum exactly 23 -> bit 1; sum 22 -> bit 0.
REQ-041 de dropped after 100 active pixels on one line -> no write at or beyond byte index 2 of that line; the next line starts at the correct address.
